// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port, and a
// one-entry-per-cycle clear sequencer. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    input  logic             clr,
    output logic             busy
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    // An address is usable if it exists and is not the hardwired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok = we && (state_q == IDLE) && addr_ok(waddr);
    assign busy  = (state_q == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem[cnt_q[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = addr_ok(raddr1) ? mem[raddr1] : '0;
        rdata2 = addr_ok(raddr2) ? mem[raddr2] : '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (raddr1 == waddr)) rdata1 = wdata;
        if (wr_ok && (raddr2 == waddr)) rdata2 = wdata;
`endif
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default 32x32, ZERO_REG=1); expected values
// are queued when stimulus is driven and popped when outputs are sampled.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        clr;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] sb_q[$];

    regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .clr(clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input logic [31:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            check(tag, obs, sb_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; clr = 1'b0;
        raddr1 = 5'($urandom_range(1, 31));
        raddr2 = 5'($urandom_range(1, 31));
        #2;
        expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
        compare("reset_rdata1", rdata1);
        compare("reset_rdata2", rdata2);
        compare("reset_busy", {31'b0, busy});
        #1 rst_n = 1'b1;

        write(5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5; #1;
        expect_val(32'hDEADBEEF); compare("write_e5", rdata1);

        write(5'd0, 32'hFFFFFFFF);
        raddr1 = 5'd0; #1;
        expect_val(32'h0); compare("zero_reg", rdata1);

        write(5'd31, 32'h12345678);
        raddr1 = 5'd31; raddr2 = 5'd31; #1;
        expect_val(32'h12345678); expect_val(32'h12345678);
        compare("e31_port1", rdata1);
        compare("e31_port2", rdata2);

        // Same-cycle view of a write depends on the forwarding build option.
        raddr2 = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h0BADF00D; #1;
`ifdef REGFILE_BYPASS_EN
        expect_val(32'h0BADF00D);
`else
        expect_val(32'h0);
`endif
        compare("bypass_same", rdata2);
        step(); we = 1'b0; #1;
        expect_val(32'h0BADF00D); compare("bypass_next", rdata2);

        for (int i = 0; i < 32; i++) write(5'(i), 32'(i + 1));
        clr = 1'b1; step(); clr = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            if (k >= 1) begin
                raddr1 = 5'(k - 1);
                expect_val(32'h0);
            end else begin
                raddr1 = 5'd0;
                expect_val(32'h0);
            end
            raddr2 = 5'(k);
            expect_val((k == 0) ? 32'h0 : 32'(k + 1));
            #1;
            compare("clr_below", rdata1);
            compare("clr_at", rdata2);
            if (k == 5) begin
                we = 1'b1; waddr = 5'd31; wdata = 32'hAAAA5555; clr = 1'b1;
            end else begin
                we = 1'b0; clr = 1'b0;
            end
            step();
            k++;
        end
        we = 1'b0; clr = 1'b0;
        expect_val(32'd32); compare("busy_len", 32'(k));
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); #1;
            expect_val(32'h0); compare("cleared", rdata1);
        end

        write(5'd20, 32'h00000055);
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        raddr1 = 5'd20; #1;
        expect_val(32'h1); expect_val(32'h55);
        compare("abort_busy_pre", {31'b0, busy});
        compare("abort_e20_pre", rdata1);
        rst_n = 1'b0; #1;
        expect_val(32'h0); compare("abort_busy", {31'b0, busy});
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); #1;
            expect_val(32'h0); compare("abort_zero", rdata1);
        end
        rst_n = 1'b1;
        write(5'd3, 32'h33333333);
        raddr1 = 5'd3; #1;
        expect_val(32'h33333333); compare("post_abort_w", rdata1);
        expect_val(32'h0); compare("post_abort_busy", {31'b0, busy});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
